// File: rtl/conv_enc_pkg.sv
// Shared types and defaults for the rate-1/2 framed convolutional encoder.
package conv_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    localparam int         DEF_K         = 3;
    localparam logic [2:0] DEF_G0        = 3'b111;
    localparam logic [2:0] DEF_G1        = 3'b101;
    localparam int         DEF_FRAME_LEN = 16;

    // Widest tap vector parity() accepts; narrower generators are zero-extended by the caller.
    localparam int PAR_W = 8;

    function automatic logic parity(input logic [PAR_W-1:0] g, input logic [PAR_W-1:0] v);
        return ^(g & v);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and generator logic; produces the code symbol for the next load.
module conv_enc_core
    import conv_enc_pkg::*;
#(
    parameter int           K  = DEF_K,
    parameter logic [K-1:0] G0 = DEF_G0,
    parameter logic [K-1:0] G1 = DEF_G1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift,
    input  logic       in_bit,
    output logic [1:0] sym
);

    logic [K-2:0] sr_reg;
    logic [K-2:0] sr_next;
    logic [K-1:0] tap;

    // sr_reg[K-2] is the newest bit, sr_reg[0] the oldest.
    assign tap = {in_bit, sr_reg};
    assign sym = {parity(PAR_W'(G0), PAR_W'(tap)), parity(PAR_W'(G1), PAR_W'(tap))};

    generate
        if (K == 2) begin : g_sr_one
            assign sr_next = in_bit;
        end else begin : g_sr_many
            assign sr_next = {in_bit, sr_reg[K-2:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg <= '0;
        end else if (shift) begin
            sr_reg <= sr_next;
        end
    end

endmodule

// File: rtl/conv_encoder_tx.sv
// Framed rate-1/2 convolutional encoder with K-1 zero tail symbols and registered valid/ready output.
// Define ERR_INJECT_EN to invert out_sym[0] on symbols loaded while the 4-bit symbol counter is 8 or 9.
module conv_encoder_tx
    import conv_enc_pkg::*;
#(
    parameter int           K         = DEF_K,
    parameter logic [K-1:0] G0        = DEF_G0,
    parameter logic [K-1:0] G1        = DEF_G1,
    parameter int           FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_tail,
    output logic       out_last,
    output logic       busy,
    output logic       inj_flag
);

    localparam int              CW       = $clog2(FRAME_LEN + 1);
    localparam int              TW       = (K > 2) ? $clog2(K - 1) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(FRAME_LEN);
    localparam logic [TW-1:0]   LAST_TAIL = TW'(K - 2);

    enc_state_t     state_reg;
    logic [CW-1:0]  bit_cnt_reg;
    logic [TW-1:0]  tail_cnt_reg;

    logic           out_valid_reg;
    logic [1:0]     out_sym_reg;
    logic           out_tail_reg;
    logic           out_last_reg;
    logic           inj_flag_reg;

    logic           ld;
    logic           accept;
    logic           tail_load;
    logic           load;
    logic           enc_in;
    logic           tail_final;
    logic           inj_next;
    logic [1:0]     sym_next;

    // The output register may take a new symbol when empty or draining this cycle.
    assign ld         = !out_valid_reg || out_ready;
    assign in_ready   = ld && ((state_reg == IDLE) || (state_reg == DATA));
    assign accept     = in_valid && in_ready;
    assign tail_load  = ld && (state_reg == TAIL);
    assign load       = accept || tail_load;
    assign enc_in     = accept && in_bit;
    assign tail_final = (tail_cnt_reg == LAST_TAIL);

    conv_enc_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .shift  (load),
        .in_bit (enc_in),
        .sym    (sym_next)
    );

`ifdef ERR_INJECT_EN
    logic [3:0] sym_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt_reg <= 4'd0;
        end else if (load) begin
            sym_cnt_reg <= sym_cnt_reg + 4'd1;
        end
    end

    assign inj_next = (sym_cnt_reg == 4'd8) || (sym_cnt_reg == 4'd9);
`else
    assign inj_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_sym_reg   <= 2'b00;
            out_tail_reg  <= 1'b0;
            out_last_reg  <= 1'b0;
            inj_flag_reg  <= 1'b0;
        end else if (ld) begin
            out_valid_reg <= load;
            out_sym_reg   <= load ? (sym_next ^ {1'b0, inj_next}) : 2'b00;
            out_tail_reg  <= tail_load;
            out_last_reg  <= tail_load && tail_final;
            inj_flag_reg  <= load && inj_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            tail_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bit_cnt_reg <= CW'(1);
                        state_reg   <= (FRAME_LEN == 1) ? TAIL : DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                        if ((bit_cnt_reg + CW'(1)) == LAST_BIT) begin
                            state_reg <= TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (tail_load) begin
                        if (tail_final) begin
                            state_reg    <= IDLE;
                            bit_cnt_reg  <= '0;
                            tail_cnt_reg <= '0;
                        end else begin
                            tail_cnt_reg <= tail_cnt_reg + TW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sym   = out_sym_reg;
    assign out_tail  = out_tail_reg;
    assign out_last  = out_last_reg;
    assign inj_flag  = inj_flag_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx: hand-computed symbol tables plus a K=3 Viterbi round trip.
module tb_conv_encoder_tx;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_tail;
    logic       out_last;
    logic       busy;
    logic       inj_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [4:0] q_rx[$];
    int         q_cyc[$];
    logic [4:0] q_exp[$];

    // Two bits per symbol, first symbol in the top bits.
    localparam logic [35:0] TBL_IMP  = 36'hEC0000000;
    localparam logic [35:0] TBL_ONES = 36'hDAAAAAAA7;
    localparam logic [35:0] TBL_ZERO = 36'h000000000;

    conv_encoder_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_tail  (out_tail),
        .out_last  (out_last),
        .busy      (busy),
        .inj_flag  (inj_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output handshake just before the edge that completes it.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready) begin
                q_rx.push_back({inj_flag, out_last, out_tail, out_sym});
                q_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
        end
    endtask

    function automatic logic inj_at(input int idx);
`ifdef ERR_INJECT_EN
        return ((idx % 16) == 8) || ((idx % 16) == 9);
`else
        return 1'b0;
`endif
    endfunction

    task automatic add_frame(input logic [35:0] tbl);
        logic [1:0] s;
        logic       inj;
        int         idx;
        for (int i = 0; i < 18; i++) begin
            idx = q_exp.size();
            s   = tbl[35 - 2*i -: 2];
            inj = inj_at(idx);
            q_exp.push_back({inj, (i == 17), (i >= 16), s ^ {1'b0, inj}});
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q_rx.delete();
        q_cyc.delete();
        q_exp.delete();
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        forever begin
            #4;
            if (in_ready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 50) begin
                chk("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic hold);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic compare_stream(input string tag);
        int n = 0;
        while (q_rx.size() < q_exp.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 32'(q_rx.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size(); i++) begin
            if (i < q_rx.size()) chk({tag, "_sym"}, 32'(q_rx[i]), 32'(q_exp[i]));
        end
        $display("%s: %0d symbols received, %0d expected", tag, q_rx.size(), q_exp.size());
    endtask

    // Hard-decision K=3 Viterbi over one 18-symbol frame, traced back from state 0.
    function automatic logic [15:0] vit_decode(input int base);
        int         pm[4];
        int         npm[4];
        logic [1:0] prv[18][4];
        logic       bv[18][4];
        logic [15:0] r;
        logic [1:0] st;
        logic [1:0] ns;
        logic [2:0] tp;
        logic [1:0] es;
        logic [1:0] rx;
        int         d;
        r = '0;
        if (q_rx.size() < base + 18) return r;
        pm = '{0, 999, 999, 999};
        for (int t = 0; t < 18; t++) begin
            npm = '{9999, 9999, 9999, 9999};
            rx  = q_rx[base + t][1:0];
            for (int s = 0; s < 4; s++) begin
                for (int b = 0; b < 2; b++) begin
                    if (t >= 16 && b == 1) continue;
                    tp = {b[0], s[1], s[0]};
                    es = {^(tp & 3'b111), ^(tp & 3'b101)};
                    d  = int'(es[1] != rx[1]) + int'(es[0] != rx[0]);
                    ns = {b[0], s[1]};
                    if (pm[s] + d < npm[ns]) begin
                        npm[ns]     = pm[s] + d;
                        prv[t][ns]  = 2'(s);
                        bv[t][ns]   = b[0];
                    end
                end
            end
            pm = npm;
        end
        st = 2'd0;
        for (int t = 17; t >= 0; t--) begin
            if (t < 16) r[15 - t] = bv[t][st];
            st = prv[t][st];
        end
        return r;
    endfunction

    task automatic vit_chk(input string tag, input int frame, input logic [15:0] w);
`ifndef ERR_INJECT_EN
        chk(tag, 32'(vit_decode(frame * 18)), 32'(w));
`endif
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_sr"}, 32'(dut.u_core.sr_reg), 32'd0);
    endtask

    task automatic stall();
        int         n = 0;
        logic [1:0] held;
        held = 2'b00;
        while (q_rx.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #4;
            if (c == 0) held = out_sym;
            else chk("bp_sym_stable", 32'(out_sym), 32'(held));
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #4;
        chk("reset_outputs", 32'({out_valid, out_sym, out_tail, out_last, inj_flag, busy}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_sr", 32'(dut.u_core.sr_reg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Impulse frame
        add_frame(TBL_IMP);
        send_frame(16'h8000, 1'b0);
        chk("t1_busy_tail", 32'(busy), 32'd1);
        chk("t1_in_ready_tail", 32'(in_ready), 32'd0);
        compare_stream("t1_impulse");
        vit_chk("t1_viterbi", 0, 16'h8000);
        idle_chk("t1_after");

        // All-ones frame
        do_reset();
        add_frame(TBL_ONES);
        send_frame(16'hFFFF, 1'b0);
        compare_stream("t2_ones");
        vit_chk("t2_viterbi", 0, 16'hFFFF);
        idle_chk("t2_after");

        // Back-pressure mid-frame
        do_reset();
        add_frame(TBL_ONES);
        fork
            send_frame(16'hFFFF, 1'b0);
            stall();
        join
        compare_stream("t3_backpressure");
        vit_chk("t3_viterbi", 0, 16'hFFFF);

        // Back-to-back frames with in_valid held
        do_reset();
        add_frame(TBL_ONES);
        add_frame(TBL_IMP);
        send_frame(16'hFFFF, 1'b1);
        send_frame(16'h8000, 1'b0);
        compare_stream("t4_b2b");
        vit_chk("t4_viterbi0", 0, 16'hFFFF);
        vit_chk("t4_viterbi1", 1, 16'h8000);
        for (int i = 1; i < q_cyc.size(); i++) chk("t4_no_gap", 32'(q_cyc[i] - q_cyc[0]), 32'(i));

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(i == 0);
        chk("t5_valid_before", 32'(out_valid), 32'd1);
        chk("t5_busy_before", 32'(busy), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_valid_after_rst", 32'(out_valid), 32'd0);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        chk("t5_sr_after_rst", 32'(dut.u_core.sr_reg), 32'd0);
        rst = 1'b0;
        q_rx.delete();
        q_cyc.delete();
        q_exp.delete();
        add_frame(TBL_IMP);
        send_frame(16'h8000, 1'b0);
        compare_stream("t5_fresh_impulse");
        vit_chk("t5_viterbi", 0, 16'h8000);

        // Three all-zero frames: exposes the injection pattern
        do_reset();
        add_frame(TBL_ZERO);
        add_frame(TBL_ZERO);
        add_frame(TBL_ZERO);
        send_frame(16'h0000, 1'b1);
        send_frame(16'h0000, 1'b1);
        send_frame(16'h0000, 1'b0);
        compare_stream("t6_zero_frames");
        idle_chk("t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
